// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - shared types, constants and request-qualifier helpers for the elevator controller
package elev_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DOOR = 2'd3
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam floor_t TOP_FLOOR = floor_t'(NUM_FLOORS - 1);
    localparam floor_t BOT_FLOOR = floor_t'(0);

    // Floors strictly above f.
    function automatic logic [NUM_FLOORS-1:0] above_mask(input floor_t f);
        logic [NUM_FLOORS-1:0] m;
        m = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
        return m << f;
    endfunction

    // Floors strictly below f.
    function automatic logic [NUM_FLOORS-1:0] below_mask(input floor_t f);
        logic [NUM_FLOORS-1:0] m;
        m = {NUM_FLOORS{1'b1}};
        return ~(m << f);
    endfunction

endpackage

// File: rtl/elev_timer.sv
// rtl/elev_timer.sv - 8-bit phase timer with clear and terminal-count compare
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clr_i       load the count with 0 on the next edge (otherwise increment)
//   tc_i        terminal count to compare against
//   done_o      count currently equals tc_i
module elev_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic [7:0] tc_i,
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = clr_i ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == tc_i);

endmodule

// File: rtl/elevator_ctrl.sv
// rtl/elevator_ctrl.sv - SCAN-style car motion controller for a 4-floor elevator
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   get_dest    pending destination requests, bit i = floor i
//   hold        door-hold button, only looked at while the door is open
//   cur_Floor   current floor (registered)
//   ce          door open / request clear enable (registered)
//   dir         travel direction, 1 = up (registered)
//   moving      car travelling between floors (registered)
module elevator_ctrl
    import elev_pkg::*;
#(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] get_dest,
    input  logic                  hold,
    output floor_t                cur_Floor,
    output logic                  ce,
    output logic                  dir,
    output logic                  moving
);

    localparam logic [7:0] TC_MOVE = 8'(MOVE_CYCLES - 1);
    localparam logic [7:0] TC_DOOR = 8'(DOOR_CYCLES - 1);

    state_t state_q, state_d;
    floor_t floor_q, floor_d;
    logic   dir_q, dir_d;
    logic   ce_q, ce_d;
    logic   moving_q, moving_d;

    logic       here, above, below;
    logic       tmr_clr, tmr_done;
    logic [7:0] tmr_tc;

    assign here  = get_dest[floor_q];
    assign above = |(get_dest & above_mask(floor_q));
    assign below = |(get_dest & below_mask(floor_q));

    assign tmr_tc = (state_q == DOOR) ? TC_DOOR : TC_MOVE;

    elev_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmr_clr),
        .tc_i   (tmr_tc),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        tmr_clr = 1'b0;

        case (state_q)
            IDLE: begin
                // Timer sits at 0 in IDLE so every phase starts from a clean count.
                tmr_clr = 1'b1;
                if (here) begin
                    state_d = DOOR;
                end else if ((dir_q == DIR_UP && above) ||
                             (dir_q == DIR_DN && above && !below)) begin
                    state_d = UP;
                    dir_d   = DIR_UP;
                end else if (below) begin
                    state_d = DOWN;
                    dir_d   = DIR_DN;
                end
            end
            UP: begin
                if (tmr_done) begin
                    state_d = IDLE;
                    floor_d = (floor_q == TOP_FLOOR) ? floor_q : floor_q + 2'd1;
                end
            end
            DOWN: begin
                if (tmr_done) begin
                    state_d = IDLE;
                    floor_d = (floor_q == BOT_FLOOR) ? floor_q : floor_q - 2'd1;
                end
            end
            DOOR: begin
                // Hold restarts the full door interval, even on the last cycle.
                if (hold) begin
                    tmr_clr = 1'b1;
                end else if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered copies of the next state, so they line up with it.
        ce_d     = (state_d == DOOR);
        moving_d = (state_d == UP) || (state_d == DOWN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            floor_q  <= BOT_FLOOR;
            dir_q    <= DIR_UP;
            ce_q     <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            ce_q     <= ce_d;
            moving_q <= moving_d;
        end
    end

    assign cur_Floor = floor_q;
    assign ce        = ce_q;
    assign dir       = dir_q;
    assign moving    = moving_q;

    // Travel past either end of the shaft must be unreachable; the floor saturates if it is not.
    a_no_up_at_top: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == UP && floor_q == TOP_FLOOR));
    a_no_down_at_bottom: assert property (@(posedge clk) disable iff (!rst_n)
        !(state_q == DOWN && floor_q == BOT_FLOOR));
    a_ce_moving_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(ce_q && moving_q));

endmodule

// File: tb/tb_elevator_ctrl.sv
// tb/tb_elevator_ctrl.sv - self-checking bench for elevator_ctrl
module tb_elevator_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] get_dest;
    logic       hold;
    logic [1:0] cur_Floor;
    logic       ce;
    logic       dir;
    logic       moving;

    int n_chk  = 0;
    int n_fail = 0;
    int excl   = 0;

    elevator_ctrl #(.MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .get_dest  (get_dest),
        .hold      (hold),
        .cur_Floor (cur_Floor),
        .ce        (ce),
        .dir       (dir),
        .moving    (moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] gd;
        logic [1:0] fl;
        logic       ce;
        logic       dir;
        logic       mv;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock with the upstream request register modelled: ce at a floor clears its bit.
    task automatic tick();
        @(posedge clk);
        #1;
        if (ce && moving) excl++;
        if (ce) get_dest[cur_Floor] = 1'b0;
    endtask

    // Request floor f and run until its stop has completed.
    task automatic goto(input int f);
        bit hit;
        hit = 1'b0;
        get_dest[f] = 1'b1;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            if (ce && cur_Floor == f[1:0]) hit = 1'b1;
        end
        chk($sformatf("reach_floor_%0d", f), int'(hit), 1);
        for (int i = 0; i < 20 && ce; i++) tick();
        chk($sformatf("door_closed_%0d", f), int'(ce), 0);
        chk($sformatf("at_floor_%0d", f), int'(cur_Floor), f);
    endtask

    initial begin
        int fl_stop[$];
        int dir_stop[$];
        int ce_cnt, rise_cnt;
        logic prev_ce;

        rst_n    = 1'b0;
        get_dest = 4'b1011;
        hold     = 1'b0;

        // Reset, then floor 0 -> floor 2 with a single request; k is row 3.
        tbl[0]  = '{1'b0, 4'b1011, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'b0110, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 4'b0100, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 4'b0100, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 4'b0100, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 4'b0100, 2'd0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b1, 4'b0100, 2'd1, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0};

        for (int i = 0; i < 18; i++) begin
            rst_n    = tbl[i].rst_n;
            get_dest = tbl[i].gd;
            @(posedge clk);
            #1;
            if (ce && moving) excl++;
            chk($sformatf("row%0d_floor", i),  int'(cur_Floor), int'(tbl[i].fl));
            chk($sformatf("row%0d_ce", i),     int'(ce),        int'(tbl[i].ce));
            chk($sformatf("row%0d_dir", i),    int'(dir),       int'(tbl[i].dir));
            chk($sformatf("row%0d_moving", i), int'(moving),    int'(tbl[i].mv));
        end

        // Move to floor 1 and let it go idle, then a request for the current floor.
        get_dest = 4'b0000;
        goto(1);
        chk("floor1_dir_down", int'(dir), 0);
        get_dest = 4'b0010;
        tick();
        chk("here_ce_e0", int'(ce), 1);
        chk("here_nomove_e0", int'(moving), 0);
        tick();
        chk("here_ce_e1", int'(ce), 1);
        tick();
        chk("here_ce_e2", int'(ce), 1);
        tick();
        chk("here_ce_e3", int'(ce), 0);
        chk("here_floor", int'(cur_Floor), 1);

        // Door hold for 5 cycles, then three more open cycles counting the last held one.
        get_dest = 4'b0010;
        tick();
        chk("hold_entry_ce", int'(ce), 1);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_ce_%0d", i), int'(ce), 1);
        end
        hold = 1'b0;
        tick();
        chk("rel_ce_1", int'(ce), 1);
        tick();
        chk("rel_ce_2", int'(ce), 1);
        tick();
        chk("rel_ce_3", int'(ce), 0);
        chk("rel_moving", int'(moving), 0);

        // Floor 2 heading up with requests at 3 and 1: serve 3 first, then reverse to 1.
        goto(2);
        chk("floor2_dir_up", int'(dir), 1);
        get_dest = 4'b1010;
        prev_ce  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ce && !prev_ce) begin
                fl_stop.push_back(int'(cur_Floor));
                dir_stop.push_back(int'(dir));
            end
            prev_ce = ce;
            if (get_dest == 4'b0000 && !ce && !moving) break;
        end
        chk("scan_num_stops", fl_stop.size(), 2);
        if (fl_stop.size() == 2) begin
            chk("scan_stop0_floor", fl_stop[0], 3);
            chk("scan_stop0_dir", dir_stop[0], 1);
            chk("scan_stop1_floor", fl_stop[1], 1);
            chk("scan_stop1_dir", dir_stop[1], 0);
        end

        // Reset in the middle of an UP phase leaving floor 2.
        goto(2);
        get_dest = 4'b1000;
        tick();
        chk("mid_up_moving", int'(moving), 1);
        tick();
        tick();
        rst_n    = 1'b0;
        get_dest = 4'b0000;
        tick();
        chk("rst_mid_floor", int'(cur_Floor), 0);
        chk("rst_mid_moving", int'(moving), 0);
        chk("rst_mid_ce", int'(ce), 0);
        chk("rst_mid_dir", int'(dir), 1);
        rst_n  = 1'b1;
        ce_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ce || moving) ce_cnt++;
        end
        chk("post_rst_quiet", ce_cnt, 0);
        chk("post_rst_floor", int'(cur_Floor), 0);

        // Request at floor 0 re-raised while the door is open: one stop only.
        get_dest = 4'b0001;
        ce_cnt   = 0;
        rise_cnt = 0;
        prev_ce  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ce) ce_cnt++;
            if (ce && !prev_ce) rise_cnt++;
            prev_ce = ce;
            if (i == 1) get_dest[0] = 1'b1;
        end
        chk("absorb_ce_cycles", ce_cnt, 3);
        chk("absorb_door_entries", rise_cnt, 1);
        chk("absorb_req_cleared", int'(get_dest), 0);

        chk("ce_moving_excl", excl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
Name: elevator_ctrl

Overview:
- Car motion controller for the 4-floor elevator. It sits directly downstream of the destination-request register.
- Consumes the pending-request vector get_dest[3:0] and schedules travel SCAN-style: it keeps its direction while requests remain ahead, otherwise reverses.
- Produces cur_Floor[1:0] and the arrival/clear enable ce, both fed back to the request register. Holding ce=1 at floor N clears get_dest[N].

Parameters:
- MOVE_CYCLES, 4: clock cycles to travel one floor; legal range 1..255.
- DOOR_CYCLES, 3: clock cycles the door stays open per stop; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- get_dest  in  4  pending destination requests, bit i = floor i.
- hold  in  1  door-hold button; only sampled in DOOR.
- cur_Floor  out  2  current car floor, registered.
- ce  out  1  arrival/clear enable; high exactly while the door is open; registered.
- dir  out  1  travel direction, 1=up, 0=down; registered.
- moving  out  1  high in UP/DOWN states; registered.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Outputs: cur_Floor=0, ce=0, dir=1, moving=0.
  - State IDLE, timer=0.
  - Reset mid-move or mid-door aborts immediately; the car is re-homed to floor 0.
- Request qualifiers, evaluated from cur_Floor:
  - here = get_dest[cur_Floor].
  - above = any get_dest bit above cur_Floor.
  - below = any get_dest bit below cur_Floor.
- IDLE decides in one cycle, with priority:
  - here -> DOOR.
  - else (dir=1 and above) or (dir=0 and above and not below) -> UP, dir=1.
  - else below -> DOWN, dir=0.
  - else stay IDLE.
- UP / DOWN:
  - Timer is cleared on entry and increments each cycle.
  - In the cycle where timer==MOVE_CYCLES-1, cur_Floor increments (UP) or decrements (DOWN) and the state returns to IDLE.
  - Entering at edge k gives the new floor at edge k+MOVE_CYCLES.
- Floor bounds:
  - UP is never entered at floor 3; DOWN is never entered at floor 0.
  - cur_Floor never wraps. If a bound is violated (which should be impossible), the floor saturates and an assertion fires.
- DOOR:
  - ce=1 from the entry edge for DOOR_CYCLES cycles; timer is cleared on entry.
  - hold=1 in any DOOR cycle reloads the timer to 0, extending the stop.
  - At timer==DOOR_CYCLES-1 with hold=0, ce drops and the state returns to IDLE.
- Requests and ce:
  - A new request for cur_Floor arriving during DOOR is absorbed, because the upstream register sees ce=1 and cur_Floor match.
  - A request for cur_Floor arriving while the car is moving away is served on a later pass.
- Simultaneous events:
  - get_dest changes during UP/DOWN do not abort travel; they are evaluated at the next IDLE.
  - Requests both above and below with dir=1 -> up first.
- Output rules:
  - ce is never asserted while moving=1.
  - moving and ce are mutually exclusive.
  - All outputs are registered; get_dest does not feed any output combinationally.

Decomposition:
- Shared package elev_pkg:
  - NUM_FLOORS=4.
  - floor_t (2-bit).
  - state_t enum {IDLE, UP, DOWN, DOOR}.
  - DIR_UP / DIR_DN constants.
- One natural sub-module, elev_timer: 8-bit counter with clear and a terminal-count compare, shared by the move and door phases.

Test Plan:
- rst_n=0 for 2 cycles with random get_dest -> cur_Floor=0, ce=0, dir=1, moving=0 on the first edge after rst_n falls.
- Floor 0, get_dest=0100 sampled at edge k, MOVE_CYCLES=4, DOOR_CYCLES=3:
  - cur_Floor=1 at k+4 and 2 at k+9.
  - ce=1 over edges k+10..k+12, ce=0 at k+13.
  - moving=0 from k+9 onward.
- Floor 1 idle, get_dest=0010 -> ce=1 next edge for 3 cycles, no motion; with hold=1 for 5 cycles, ce stays high 3 cycles past hold release.
- Car at floor 2 going up, get_dest=1010 -> visits floor 3 first (ce at 3), then reverses, dir=0, stops at 1.
- rst_n=0 at the middle of an UP phase at floor 2 -> next edge cur_Floor=0, moving=0, IDLE; no ce pulse.
- get_dest=0001 at floor 0 with get_dest[0] reasserted during DOOR -> a single stop, no second DOOR entry, and ce is never seen with moving=1.
